cm0_pmu_cdc_send_hs: RTL and testbench

//  Parametrised CDC-safe send register: launches a WIDTH-bit word to another clock domain with a
//  4-phase REQ/ACK handshake. Data and REQ come straight from flops (no logic after the register),
//  so they never glitch. Used by the PMU for multi-bit control words into the receive domain.

---
 rtl/cm0_pmu_cdc_send_hs_if.sv | 40 ++++
 rtl/cm0_pmu_cdc_send_hs.sv | 197 +++++++++++++++++++
 tb/tb_cm0_pmu_cdc_send_hs.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cm0_pmu_cdc_send_hs_if.sv
// -----------------------------------------------------------------------------
// cm0_pmu_cdc_send_hs_if
// Signal bundle for the PMU CDC send register: the local send request/accept
// pair plus the launched data word and the REQ/ACK handshake that crosses into
// the receive domain. Clock and reset are not part of the bundle.
// -----------------------------------------------------------------------------
interface cm0_pmu_cdc_send_hs_if #(
   parameter int WIDTH = 8
);
   logic             SENDVALID;
   logic [WIDTH-1:0] SENDDATA;
   logic             SENDREADY;
   logic             SENDDONE;
   logic [WIDTH-1:0] REGDO;
   logic             REGREQ;
   logic             REGACK;

   // Send register side: takes local requests and the remote ACK,
   // launches data and REQ.
   modport master (
      input  SENDVALID,
      input  SENDDATA,
      input  REGACK,
      output SENDREADY,
      output SENDDONE,
      output REGDO,
      output REGREQ
   );

   // Environment side: the local requester together with the receive domain.
   modport slave (
      output SENDVALID,
      output SENDDATA,
      output REGACK,
      input  SENDREADY,
      input  SENDDONE,
      input  REGDO,
      input  REGREQ
   );
endinterface

// File: rtl/cm0_pmu_cdc_send_hs.sv
// -----------------------------------------------------------------------------
// cm0_pmu_cdc_send_hs
// CDC-safe send register. A WIDTH-bit word is captured on accept and launched
// to another clock domain with a 4-phase REQ/ACK handshake. REGDO and REGREQ
// come straight from flops, so the receiver never sees combinational glitches.
// REGACK is asynchronous and only its synchronised copy steers the FSM.
//
// Handshake sequence (edge k = accept edge):
//   IDLE  --accept@k-->  SETUP  --k+1, REQ=1-->  REQ  --ack_sync=1, REQ=0-->
//   REL   --ack_sync=0, SENDDONE pulse-->  IDLE
// -----------------------------------------------------------------------------
module cm0_pmu_cdc_send_hs #(
   parameter int               WIDTH       = 8,
   parameter logic [WIDTH-1:0] RST_VAL     = {WIDTH{1'b0}},
   parameter int               SYNC_STAGES = 2
) (
   input  logic                  REGCLK,
   input  logic                  REGRESETn,
   cm0_pmu_cdc_send_hs_if.master bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      REQ   = 2'd2,
      REL   = 2'd3
   } state_t;

   state_t                 state_q;
   state_t                 state_d;

   logic [SYNC_STAGES-1:0] ack_sync_q;
   logic                   ack_sync;
   logic                   ack_seen;
   logic                   rst_done_q;

   logic [WIDTH-1:0]       regdo_q;
   logic                   regreq_q;
   logic                   regreq_d;
   logic                   senddone_q;
   logic                   senddone_d;
   logic                   load_data;

   logic                   send_ready;
   logic                   accept;

   // ---------------------------------------------------------------------------
   // ACK synchroniser: REGACK enters the REGCLK domain through a plain shift
   // chain; only the last stage (ack_sync) is a settled level.
   // NOTE: the synchroniser flops are reset as well, so an ACK level captured
   // before reset cannot leak into the FSM after release.
   // ---------------------------------------------------------------------------
   always_ff @(posedge REGCLK or negedge REGRESETn) begin
      if (!REGRESETn) begin
         ack_sync_q <= '0;
      end else begin
         ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], bus.REGACK};
      end
   end

   assign ack_sync = ack_sync_q[SYNC_STAGES-1];

   // Any stage still holding a 1 means an ACK is high or still draining out
   // of the chain. IDLE refuses new words until the whole chain reads 0, so a
   // stale ACK held across reset release keeps the block not-ready from the
   // very first cycle. A first-stage level that resolves late only shifts
   // readiness by one cycle; it never completes a handshake.
   assign ack_seen = |ack_sync_q;

   // Marks the first clock after reset release; SENDREADY is held low until then.
   always_ff @(posedge REGCLK or negedge REGRESETn) begin
      if (!REGRESETn) begin
         rst_done_q <= 1'b0;
      end else begin
         rst_done_q <= 1'b1;
      end
   end

   // Ready is a decode of registered state only: IDLE, out of reset, no ACK
   // anywhere in the synchroniser.
   assign send_ready = rst_done_q && (state_q == IDLE) && !ack_seen;
   assign accept     = bus.SENDVALID && send_ready;

   // ---------------------------------------------------------------------------
   // FSM state register.
   // NOTE: all sequential state is written with non-blocking assignments so
   // every flop samples values from before the edge, independent of process
   // evaluation order.
   // ---------------------------------------------------------------------------
   always_ff @(posedge REGCLK or negedge REGRESETn) begin
      if (!REGRESETn) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic: advances only on ack_sync levels, never on edges,
   // so a short ACK pulse can at worst be missed, never double-counted.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept)    state_d = SETUP;
         SETUP:                  state_d = REQ;
         REQ:     if (ack_sync)  state_d = REL;
         REL:     if (!ack_sync) state_d = IDLE;
         default:                state_d = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // FSM output logic: next values for the registered outputs and the data
   // load enable.
   // NOTE: every signal gets a default before the case so no path leaves one
   // unassigned, which would otherwise infer a latch.
   // ---------------------------------------------------------------------------
   always_comb begin
      regreq_d   = regreq_q;
      senddone_d = 1'b0;
      load_data  = 1'b0;
      unique case (state_q)
         IDLE: begin
            regreq_d  = 1'b0;
            load_data = accept;
         end
         SETUP: begin
            // Data was captured one edge earlier and is settled; raise REQ now.
            regreq_d = 1'b1;
         end
         REQ: begin
            if (ack_sync) begin
               regreq_d = 1'b0;
            end
         end
         REL: begin
            regreq_d = 1'b0;
            if (!ack_sync) begin
               senddone_d = 1'b1;
            end
         end
         default: begin
            regreq_d = 1'b0;
         end
      endcase
   end

   // Handshake output flops: REQ and the one-cycle completion pulse.
   always_ff @(posedge REGCLK or negedge REGRESETn) begin
      if (!REGRESETn) begin
         regreq_q   <= 1'b0;
         senddone_q <= 1'b0;
      end else begin
         regreq_q   <= regreq_d;
         senddone_q <= senddone_d;
      end
   end

   // Data launch register: enabled on accept only. A rewrite with an identical
   // value leaves every bit at its old level, so the receiver sees no edge.
   always_ff @(posedge REGCLK or negedge REGRESETn) begin
      if (!REGRESETn) begin
         regdo_q <= RST_VAL;
      end else if (load_data) begin
         regdo_q <= bus.SENDDATA;
      end
   end

   assign bus.REGDO     = regdo_q;
   assign bus.REGREQ    = regreq_q;
   assign bus.SENDDONE  = senddone_q;
   assign bus.SENDREADY = send_ready;

`ifdef ARM_ASSERT_ON
   // Inputs and internal decision points are never unknown out of reset.
   a_valid_known: assert property (@(posedge REGCLK) disable iff (!REGRESETn)
      !$isunknown(bus.SENDVALID));
   a_ack_sync_known: assert property (@(posedge REGCLK) disable iff (!REGRESETn)
      !$isunknown(ack_sync));
   a_state_known: assert property (@(posedge REGCLK) disable iff (!REGRESETn)
      !$isunknown(state_q));

   // Launched data is frozen for the whole handshake.
   a_regdo_hold: assert property (@(posedge REGCLK) disable iff (!REGRESETn)
      (state_q != IDLE) |=> $stable(regdo_q));
   a_regdo_only_on_accept: assert property (@(posedge REGCLK) disable iff (!REGRESETn)
      !accept |=> $stable(regdo_q));

   // REQ can only be raised on leaving SETUP.
   a_req_rise_from_setup: assert property (@(posedge REGCLK) disable iff (!REGRESETn)
      $rose(regreq_q) |-> ($past(state_q) == SETUP));

   // Completion is a single-cycle pulse.
   a_done_pulse: assert property (@(posedge REGCLK) disable iff (!REGRESETn)
      senddone_q |=> !senddone_q);
`endif

endmodule

// File: tb/tb_cm0_pmu_cdc_send_hs.sv
// -----------------------------------------------------------------------------
// tb_cm0_pmu_cdc_send_hs
// Self-checking bench for the CDC send register. An 8-bit instance
// (RST_VAL=8'hA5) takes directed reset, timing, hold and reset-abort
// sequences with a cycle-accurate hand-driven receiver; 1-bit and 32-bit
// instances take random back-to-back traffic against asynchronous receiver
// models. Expected words go into queues when accepted and are popped when the
// receive side samples REGDO under REQ.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_cm0_pmu_cdc_send_hs;

   logic REGCLK = 1'b0;
   logic rstn_a;
   logic rstn_b;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0]  q8[$];
   logic [31:0] q32[$];
   logic        q1[$];

   logic [7:0]  last8;
   int          regdo_chg = 0;
   int          req_rise  = 0;
   int          n_rx32    = 0;
   int          n_rx1     = 0;

   always #5 REGCLK = ~REGCLK;

   cm0_pmu_cdc_send_hs_if #(.WIDTH(8))  if8  ();
   cm0_pmu_cdc_send_hs_if #(.WIDTH(1))  if1  ();
   cm0_pmu_cdc_send_hs_if #(.WIDTH(32)) if32 ();

   cm0_pmu_cdc_send_hs #(.WIDTH(8), .RST_VAL(8'hA5), .SYNC_STAGES(2)) u_dut8 (
      .REGCLK    (REGCLK),
      .REGRESETn (rstn_a),
      .bus       (if8.master)
   );

   cm0_pmu_cdc_send_hs #(.WIDTH(1), .RST_VAL(1'b0), .SYNC_STAGES(2)) u_dut1 (
      .REGCLK    (REGCLK),
      .REGRESETn (rstn_b),
      .bus       (if1.master)
   );

   cm0_pmu_cdc_send_hs #(.WIDTH(32), .RST_VAL(32'h0), .SYNC_STAGES(3)) u_dut32 (
      .REGCLK    (REGCLK),
      .REGRESETn (rstn_b),
      .bus       (if32.master)
   );

   // Edge counters on the 8-bit launch outputs, used to prove glitch freedom.
   always @(if8.REGDO) regdo_chg++;
   always @(posedge if8.REGREQ) req_rise++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge REGCLK);
      #1;
   endtask

   // Optionally scramble the 8-bit requester inputs between edges.
   task automatic stir(input bit on);
      if (on) begin
         if8.SENDDATA  = 8'($urandom);
         if8.SENDVALID = 1'($urandom);
      end
   endtask

   // One complete 8-bit handshake with cycle-exact timing checks.
   task automatic send8(input logic [7:0] d, input int ack_dly, input bit toggle);
      int         t;
      int         chg_pre;
      int         chg0;
      int         rise0;
      logic [7:0] exp;
      if8.SENDDATA  = d;
      if8.SENDVALID = 1'b1;
      t = 0;
      while (!if8.SENDREADY && t < 50) begin
         tick();
         t++;
      end
      check("ready_wait8", 32'(t < 50), 32'd1);
      q8.push_back(d);
      chg_pre = regdo_chg;
      rise0   = req_rise;
      tick();                                   // edge k: accept
      check("regdo_at_k", if8.REGDO, d);
      check("regdo_load_edges", regdo_chg - chg_pre, 32'(last8 != d));
      last8 = d;
      check("req_low_at_k", if8.REGREQ, 1'b0);
      check("ready_low_at_k", if8.SENDREADY, 1'b0);
      chg0 = regdo_chg;
      if8.SENDVALID = 1'b0;
      stir(toggle);
      tick();                                   // edge k+1
      check("req_high_k1", if8.REGREQ, 1'b1);
      check("sb8_nonempty", 32'(q8.size() != 0), 32'd1);
      if (q8.size() != 0) begin
         exp = q8.pop_front();
         check("sb8_word", if8.REGDO, exp);
      end
      repeat (ack_dly) begin
         stir(toggle);
         tick();
      end
      check("req_hold", if8.REGREQ, 1'b1);
      if8.REGACK = 1'b1;
      stir(toggle); tick();
      check("req_after_ack1", if8.REGREQ, 1'b1);
      stir(toggle); tick();
      check("req_after_ack2", if8.REGREQ, 1'b1);
      stir(toggle); tick();
      check("req_fall_ack3", if8.REGREQ, 1'b0);
      if8.REGACK = 1'b0;
      stir(toggle); tick();
      check("done_rel1", if8.SENDDONE, 1'b0);
      stir(toggle); tick();
      check("done_rel2", if8.SENDDONE, 1'b0);
      stir(toggle); tick();
      check("done_pulse", if8.SENDDONE, 1'b1);
      check("ready_with_done", if8.SENDREADY, 1'b1);
      if8.SENDVALID = 1'b0;
      tick();
      check("done_clear", if8.SENDDONE, 1'b0);
      check("ready_after_done", if8.SENDREADY, 1'b1);
      check("regdo_hold", if8.REGDO, d);
      check("regdo_no_glitch", regdo_chg - chg0, 32'd0);
      check("req_single_rise", req_rise - rise0, 32'd1);
   endtask

   // Asynchronous receiver for the 32-bit instance.
   initial begin : rcv32
      logic [31:0] exp;
      if32.REGACK = 1'b0;
      forever begin
         @(posedge if32.REGREQ);
         #($urandom_range(1, 40));
         check("sb32_nonempty", 32'(q32.size() != 0), 32'd1);
         if (q32.size() != 0) begin
            exp = q32.pop_front();
            check("sb32_word", if32.REGDO, exp);
         end
         n_rx32++;
         if32.REGACK = 1'b1;
         @(negedge if32.REGREQ);
         #($urandom_range(1, 40));
         if32.REGACK = 1'b0;
      end
   end

   // Asynchronous receiver for the 1-bit instance.
   initial begin : rcv1
      logic exp;
      if1.REGACK = 1'b0;
      forever begin
         @(posedge if1.REGREQ);
         #($urandom_range(1, 40));
         check("sb1_nonempty", 32'(q1.size() != 0), 32'd1);
         if (q1.size() != 0) begin
            exp = q1.pop_front();
            check("sb1_word", if1.REGDO, exp);
         end
         n_rx1++;
         if1.REGACK = 1'b1;
         @(negedge if1.REGREQ);
         #($urandom_range(1, 40));
         if1.REGACK = 1'b0;
      end
   end

   initial begin : watchdog
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int t;
      rstn_a        = 1'b1;
      rstn_b        = 1'b1;
      if8.SENDVALID = 1'b0;
      if8.SENDDATA  = 8'h00;
      if8.REGACK    = 1'b0;
      if1.SENDVALID = 1'b0;
      if1.SENDDATA  = 1'b0;
      if32.SENDVALID = 1'b0;
      if32.SENDDATA  = 32'h0;
      last8 = 8'hA5;

      // Reset asserted mid-clock: outputs take reset values at once.
      #1;
      rstn_a = 1'b0;
      rstn_b = 1'b0;
      #2;
      check("rst_regdo", if8.REGDO, 8'hA5);
      check("rst_regreq", if8.REGREQ, 1'b0);
      check("rst_done", if8.SENDDONE, 1'b0);
      check("rst_ready", if8.SENDREADY, 1'b0);
      check("rst_regdo32", if32.REGDO, 32'h0);
      tick();
      tick();
      check("rst_ready_held", if8.SENDREADY, 1'b0);
      rstn_a = 1'b0;
      rstn_b = 1'b1;
      rstn_a = 1'b1;
      check("ready_at_release", if8.SENDREADY, 1'b0);
      tick();
      check("ready_1cyc_after_release", if8.SENDREADY, 1'b1);
      check("ready32_after_release", if32.SENDREADY, 1'b1);

      // Basic send, then identical value with toggling inputs, then another.
      send8(8'h3C, 3, 1'b0);
      send8(8'h3C, 4, 1'b1);
      send8(8'h5A, 1, 1'b1);

      // Reset while REQ is high: outputs return to reset values immediately.
      if8.SENDDATA  = 8'h11;
      if8.SENDVALID = 1'b1;
      check("abort_ready", if8.SENDREADY, 1'b1);
      tick();
      if8.SENDVALID = 1'b0;
      check("abort_regdo", if8.REGDO, 8'h11);
      tick();
      check("abort_req_high", if8.REGREQ, 1'b1);
      tick();
      #3;
      rstn_a = 1'b0;
      #1;
      check("abort_req_low", if8.REGREQ, 1'b0);
      check("abort_regdo_rst", if8.REGDO, 8'hA5);
      check("abort_ready_low", if8.SENDREADY, 1'b0);
      check("abort_done_low", if8.SENDDONE, 1'b0);
      last8 = 8'hA5;
      tick();
      tick();
      rstn_a = 1'b1;
      tick();
      check("abort_ready_after", if8.SENDREADY, 1'b1);
      send8(8'hFF, 2, 1'b0);

      // Stale ACK held high across reset release.
      #3;
      rstn_a     = 1'b0;
      if8.REGACK = 1'b1;
      last8      = 8'hA5;
      tick();
      tick();
      rstn_a = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         check("stale_ack_not_ready", if8.SENDREADY, 1'b0);
      end
      if8.REGACK = 1'b0;
      tick();
      check("stale_ack_drain1", if8.SENDREADY, 1'b0);
      tick();
      check("stale_ack_ready", if8.SENDREADY, 1'b1);
      check("stale_ack_regdo", if8.REGDO, 8'hA5);
      check("stale_ack_req", if8.REGREQ, 1'b0);
      send8(8'h96, 0, 1'b1);

      // Random back-to-back traffic on the 1-bit and 32-bit instances.
      fork
         begin : drv32
            int tw;
            for (int i = 0; i < 100; i++) begin
               if ($urandom_range(0, 3) == 0) begin
                  if32.SENDVALID = 1'b0;
                  tick();
               end
               if32.SENDDATA  = $urandom;
               if32.SENDVALID = 1'b1;
               tw = 0;
               while (!if32.SENDREADY && tw < 200) begin
                  tick();
                  tw++;
               end
               check("ready_wait32", 32'(tw < 200), 32'd1);
               q32.push_back(if32.SENDDATA);
               tick();
            end
            if32.SENDVALID = 1'b0;
         end
         begin : drv1
            int tw;
            for (int i = 0; i < 100; i++) begin
               if ($urandom_range(0, 3) == 0) begin
                  if1.SENDVALID = 1'b0;
                  tick();
               end
               if1.SENDDATA  = 1'($urandom);
               if1.SENDVALID = 1'b1;
               tw = 0;
               while (!if1.SENDREADY && tw < 200) begin
                  tick();
                  tw++;
               end
               check("ready_wait1", 32'(tw < 200), 32'd1);
               q1.push_back(if1.SENDDATA);
               tick();
            end
            if1.SENDVALID = 1'b0;
         end
      join

      t = 0;
      while ((n_rx32 < 100 || n_rx1 < 100) && t < 3000) begin
         tick();
         t++;
      end
      repeat (20) tick();
      check("rx32_count", n_rx32, 32'd100);
      check("rx1_count", n_rx1, 32'd100);
      check("q32_drained", q32.size(), 32'd0);
      check("q1_drained", q1.size(), 32'd0);
      check("req32_idle", if32.REGREQ, 1'b0);
      check("ready32_idle", if32.SENDREADY, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
